// File: rtl/ps2_scancode_decoder_if.sv
// Upstream scan-code FIFO pop handshake plus the decoded key-event bus.
interface ps2_scancode_decoder_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_rdn;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic [3:0] key_mods;
  logic       key_valid;
  logic       key_ack;

  modport master (
    input  kb_data, kb_ready, key_ack,
    output kb_rdn, key_code, key_ext, key_break, key_ascii, key_mods, key_valid
  );

  modport slave (
    output kb_data, kb_ready, key_ack,
    input  kb_rdn, key_code, key_ext, key_break, key_ascii, key_mods, key_valid
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops prefix/terminal bytes from an upstream FIFO and
// holds one decoded key event (code, ext/break flags, ASCII, modifiers) until acked.
module ps2_scancode_decoder #(
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic                   clk,
  input  logic                   clrn,
  ps2_scancode_decoder_if.master bus
);

  localparam int unsigned CntW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {StIdle, StGotE0, StGotF0, StGotE0F0, StSkip} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_skip_cnt, w_skip_cnt_d;
  logic            r_lshift, r_rshift, r_ctrl, r_alt, r_caps;
  logic            w_lshift_d, w_rshift_d, w_ctrl_d, w_alt_d, w_caps_d;
  logic            r_valid, r_ext, r_break;
  logic [7:0]      r_code, r_ascii;
  logic [3:0]      r_mods;
  logic            w_terminal, w_ev_ext, w_ev_brk, w_pop, w_load, w_is_drop, w_is_letter;
  logic [7:0]      w_byte, w_ev_code, w_lower, w_ascii;

  assign w_byte    = bus.kb_data;
  assign w_is_drop = w_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always_comb begin
    w_state_d    = r_state;
    w_skip_cnt_d = r_skip_cnt;
    w_terminal   = 1'b0;
    w_ev_code    = w_byte;
    w_ev_ext     = 1'b0;
    w_ev_brk     = 1'b0;
    if (r_state == StSkip) begin
      if (r_skip_cnt <= CntW'(1)) begin
        w_terminal   = 1'b1;
        w_ev_code    = 8'hE1;
        w_ev_ext     = 1'b1;
        w_state_d    = StIdle;
        w_skip_cnt_d = '0;
      end else begin
        w_skip_cnt_d = r_skip_cnt - CntW'(1);
      end
    end else if (w_byte == 8'hE1) begin
      w_state_d    = StSkip;
      w_skip_cnt_d = CntW'(PAUSE_SKIP);
    end else if (w_byte == 8'hE0) begin
      w_state_d = StGotE0;
    end else if (w_byte == 8'hF0) begin
      // A second F0 after E0 F0 restarts as a plain break.
      w_state_d = (r_state == StGotE0) ? StGotE0F0 : StGotF0;
    end else if (!(r_state == StIdle && w_is_drop)) begin
      w_terminal = 1'b1;
      w_ev_ext   = (r_state == StGotE0) || (r_state == StGotE0F0);
      w_ev_brk   = (r_state == StGotF0) || (r_state == StGotE0F0);
      w_state_d  = StIdle;
    end
  end

  // Terminal bytes stay in the FIFO until the event register can take them.
  assign w_pop  = ~clrn & bus.kb_ready & (~w_terminal | ~r_valid | bus.key_ack);
  assign w_load = w_pop & w_terminal;

  always_comb begin
    w_lshift_d = r_lshift;
    w_rshift_d = r_rshift;
    w_ctrl_d   = r_ctrl;
    w_alt_d    = r_alt;
    w_caps_d   = r_caps;
    if (w_load) begin
      case (w_ev_code)
        8'h12:   w_lshift_d = ~w_ev_brk;
        8'h59:   w_rshift_d = ~w_ev_brk;
        8'h14:   w_ctrl_d   = ~w_ev_brk;
        8'h11:   w_alt_d    = ~w_ev_brk;
        8'h58:   w_caps_d   = r_caps ^ ~w_ev_brk;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_lower = 8'h00;
    case (w_ev_code)
      8'h1C: w_lower = "a";  8'h32: w_lower = "b";  8'h21: w_lower = "c";  8'h23: w_lower = "d";
      8'h24: w_lower = "e";  8'h2B: w_lower = "f";  8'h34: w_lower = "g";  8'h33: w_lower = "h";
      8'h43: w_lower = "i";  8'h3B: w_lower = "j";  8'h42: w_lower = "k";  8'h4B: w_lower = "l";
      8'h3A: w_lower = "m";  8'h31: w_lower = "n";  8'h44: w_lower = "o";  8'h4D: w_lower = "p";
      8'h15: w_lower = "q";  8'h2D: w_lower = "r";  8'h1B: w_lower = "s";  8'h2C: w_lower = "t";
      8'h3C: w_lower = "u";  8'h2A: w_lower = "v";  8'h1D: w_lower = "w";  8'h22: w_lower = "x";
      8'h35: w_lower = "y";  8'h1A: w_lower = "z";
      8'h45: w_lower = "0";  8'h16: w_lower = "1";  8'h1E: w_lower = "2";  8'h26: w_lower = "3";
      8'h25: w_lower = "4";  8'h2E: w_lower = "5";  8'h36: w_lower = "6";  8'h3D: w_lower = "7";
      8'h3E: w_lower = "8";  8'h46: w_lower = "9";
      8'h29: w_lower = 8'h20;
      8'h5A: w_lower = 8'h0D;
      default: w_lower = 8'h00;
    endcase
  end

  assign w_is_letter = (w_lower >= "a") && (w_lower <= "z");

  always_comb begin
    w_ascii = w_lower;
    if (w_ev_ext) begin
      w_ascii = 8'h00;
    end else if (w_is_letter && ((w_lshift_d | w_rshift_d) ^ w_caps_d)) begin
      w_ascii = w_lower - 8'h20;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_state    <= StIdle;
      r_skip_cnt <= '0;
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_ctrl     <= 1'b0;
      r_alt      <= 1'b0;
      r_caps     <= 1'b0;
      r_valid    <= 1'b0;
      r_code     <= 8'h00;
      r_ext      <= 1'b0;
      r_break    <= 1'b0;
      r_ascii    <= 8'h00;
      r_mods     <= 4'h0;
    end else begin
      if (w_pop) begin
        r_state    <= w_state_d;
        r_skip_cnt <= w_skip_cnt_d;
      end
      r_lshift <= w_lshift_d;
      r_rshift <= w_rshift_d;
      r_ctrl   <= w_ctrl_d;
      r_alt    <= w_alt_d;
      r_caps   <= w_caps_d;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_ev_code;
        r_ext   <= w_ev_ext;
        r_break <= w_ev_brk;
        r_ascii <= w_ascii;
        r_mods  <= {w_caps_d, w_alt_d, w_ctrl_d, w_lshift_d | w_rshift_d};
      end else if (bus.key_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.kb_rdn    = w_pop;
  assign bus.key_valid = r_valid;
  assign bus.key_code  = r_code;
  assign bus.key_ext   = r_ext;
  assign bus.key_break = r_break;
  assign bus.key_ascii = r_ascii;
  assign bus.key_mods  = r_mods;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed key sequences plus random bytes, all checked
// against a byte-level reference model of the scan-code rules.
module tb_ps2_scancode_decoder;
  localparam int unsigned PauseSkip = 7;

  logic clk = 1'b0;
  logic clrn;
  int   total = 0;
  int   bad = 0;
  byte unsigned q[$];

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.PAUSE_SKIP(PauseSkip)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  // Reference model: pending prefix flags, pause skip count, modifiers, expected event.
  bit           m_ext, m_brk, m_ls, m_rs, m_ctrl, m_alt, m_caps, m_valid, m_eext, m_ebrk;
  int           m_skip;
  byte unsigned m_code, m_ascii;
  logic [3:0]   m_mods;

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  byte unsigned pool[16] = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'hE0, 8'hF0,
    8'hF0, 8'h45, 8'h29, 8'h5A, 8'hAA, 8'h75, 8'hE1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic byte unsigned ref_ascii(input byte unsigned c, input bit ext,
                                             input bit upper);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return 8'(i) + (upper ? 8'h41 : 8'h61);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'(i) + 8'h30;
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic bit needs_load(input byte unsigned b);
    if (m_skip > 0) return m_skip == 1;
    if (b inside {8'hE0, 8'hF0, 8'hE1}) return 1'b0;
    if (!m_ext && !m_brk && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_emit(input byte unsigned c, input bit ext, input bit brk);
    if (c == 8'h12) m_ls = !brk;
    if (c == 8'h59) m_rs = !brk;
    if (c == 8'h14) m_ctrl = !brk;
    if (c == 8'h11) m_alt = !brk;
    if (c == 8'h58 && !brk) m_caps = !m_caps;
    m_valid = 1'b1;
    m_code  = c;
    m_eext  = ext;
    m_ebrk  = brk;
    m_ascii = ref_ascii(c, ext, (m_ls | m_rs) ^ m_caps);
    m_mods  = {m_caps, m_alt, m_ctrl, m_ls | m_rs};
  endfunction

  function automatic void model_pop(input byte unsigned b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) model_emit(8'hE1, 1'b1, 1'b0);
    end else if (b == 8'hE1) begin
      m_skip = PauseSkip;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_ext = m_ext && !m_brk;
      m_brk = 1'b1;
    end else if (needs_load(b)) begin
      model_emit(b, m_ext, m_brk);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    {m_ext, m_brk, m_ls, m_rs, m_ctrl, m_alt, m_caps, m_valid, m_eext, m_ebrk} = '0;
    m_skip  = 0;
    m_code  = 8'h00;
    m_ascii = 8'h00;
    m_mods  = 4'h0;
  endfunction

  task automatic check_outputs();
    chk("key_valid", 32'(bus.key_valid), 32'(m_valid));
    if (m_valid) begin
      chk("key_code", 32'(bus.key_code), 32'(m_code));
      chk("key_ext", 32'(bus.key_ext), 32'(m_eext));
      chk("key_break", 32'(bus.key_break), 32'(m_ebrk));
      chk("key_ascii", 32'(bus.key_ascii), 32'(m_ascii));
      chk("key_mods", 32'(bus.key_mods), 32'(m_mods));
    end
  endtask

  task automatic drive_inputs(input bit ack);
    bus.key_ack  = ack;
    bus.kb_ready = (q.size() != 0);
    bus.kb_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic tick(input bit ack);
    bit exp_pop;
    bit did_pop;
    drive_inputs(ack);
    #1;
    exp_pop = (q.size() != 0) && (!needs_load(q[0]) || !m_valid || ack);
    chk("kb_rdn", 32'(bus.kb_rdn), 32'(exp_pop));
    did_pop = bus.kb_rdn;
    @(posedge clk);
    if (m_valid && ack) m_valid = 1'b0;
    if (did_pop && q.size() != 0) model_pop(q.pop_front());
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    clrn = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      drive_inputs(1'b0);
      #1;
      chk("rst_kb_rdn", 32'(bus.kb_rdn), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(bus.key_valid), 32'd0);
      chk("rst_code", 32'(bus.key_code), 32'd0);
      chk("rst_ext_brk", 32'({bus.key_ext, bus.key_break}), 32'd0);
      chk("rst_ascii", 32'(bus.key_ascii), 32'd0);
      chk("rst_mods", 32'(bus.key_mods), 32'd0);
    end
    clrn = 1'b0;
  endtask

  task automatic wait_event(input string tag, input byte unsigned code, input bit ext,
                            input bit brk, input byte unsigned ascii, input logic [3:0] mods,
                            input bit ack_after);
    int n = 0;
    while (!bus.key_valid && n < 40) begin
      tick(1'b0);
      n++;
    end
    chk({tag, ".valid"}, 32'(bus.key_valid), 32'd1);
    chk({tag, ".code"}, 32'(bus.key_code), 32'(code));
    chk({tag, ".ext"}, 32'(bus.key_ext), 32'(ext));
    chk({tag, ".brk"}, 32'(bus.key_break), 32'(brk));
    chk({tag, ".ascii"}, 32'(bus.key_ascii), 32'(ascii));
    chk({tag, ".mods"}, 32'(bus.key_mods), 32'(mods));
    if (ack_after) tick(1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b1;
    drive_inputs(1'b0);
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Plain make then break of 'a'.
    q.push_back(8'h1C);
    wait_event("a_make", 8'h1C, 0, 0, 8'h61, 4'h0, 1);
    q = '{8'hF0, 8'h1C};
    wait_event("a_break", 8'h1C, 0, 1, 8'h61, 4'h0, 1);

    // Shift, caps lock and their XOR on letters.
    q = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    wait_event("lshift_make", 8'h12, 0, 0, 8'h00, 4'h1, 1);
    wait_event("A_shift", 8'h1C, 0, 0, 8'h41, 4'h1, 1);
    wait_event("lshift_brk", 8'h12, 0, 1, 8'h00, 4'h0, 1);
    wait_event("a_noshift", 8'h1C, 0, 0, 8'h61, 4'h0, 1);
    q = '{8'h58, 8'h1C, 8'h59, 8'h1C, 8'hF0, 8'h59, 8'hF0, 8'h58, 8'h58};
    wait_event("caps_on", 8'h58, 0, 0, 8'h00, 4'h8, 1);
    wait_event("A_caps", 8'h1C, 0, 0, 8'h41, 4'h8, 1);
    wait_event("rshift_make", 8'h59, 0, 0, 8'h00, 4'h9, 1);
    wait_event("a_caps_shift", 8'h1C, 0, 0, 8'h61, 4'h9, 1);
    wait_event("rshift_brk", 8'h59, 0, 1, 8'h00, 4'h8, 1);
    wait_event("caps_brk", 8'h58, 0, 1, 8'h00, 4'h8, 1);
    wait_event("caps_off", 8'h58, 0, 0, 8'h00, 4'h0, 1);

    // Extended break; prefixes alone make no event.
    q = '{8'hE0, 8'hF0, 8'h75};
    tick(1'b0);
    chk("e0_no_event", 32'(bus.key_valid), 32'd0);
    tick(1'b0);
    chk("f0_no_event", 32'(bus.key_valid), 32'd0);
    wait_event("ext_brk", 8'h75, 1, 1, 8'h00, 4'h0, 1);

    // Pause sequence collapses to a single E1 event.
    q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    wait_event("pause", 8'hE1, 1, 0, 8'h00, 4'h0, 1);
    repeat (3) tick(1'b0);
    chk("pause_single", 32'(bus.key_valid), 32'd0);
    chk("pause_all_popped", 32'(q.size()), 32'd0);

    // Back-pressure: event held, next byte waits, ack cycle reloads.
    q = '{8'h1C, 8'h32};
    wait_event("hold_first", 8'h1C, 0, 0, 8'h61, 4'h0, 0);
    repeat (4) begin
      tick(1'b0);
      chk("hold_code", 32'(bus.key_code), 32'h1C);
    end
    chk("hold_no_pop", 32'(q.size()), 32'd1);
    tick(1'b1);
    chk("ack_reload_valid", 32'(bus.key_valid), 32'd1);
    chk("ack_reload_code", 32'(bus.key_code), 32'h32);
    chk("ack_reload_ascii", 32'(bus.key_ascii), 32'h62);
    tick(1'b1);

    // Digits, space, enter, extended letter, repeated prefixes.
    q = '{8'h16, 8'h29, 8'h5A, 8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'hF0, 8'hE0, 8'h1C};
    wait_event("digit1", 8'h16, 0, 0, 8'h31, 4'h0, 1);
    wait_event("space", 8'h29, 0, 0, 8'h20, 4'h0, 1);
    wait_event("enter", 8'h5A, 0, 0, 8'h0D, 4'h0, 1);
    wait_event("ext_letter", 8'h1C, 1, 0, 8'h00, 4'h0, 1);
    wait_event("f0_restart", 8'h1C, 0, 1, 8'h61, 4'h0, 1);
    wait_event("e0_restart", 8'h1C, 1, 0, 8'h00, 4'h0, 1);

    // Reset mid-sequence, then idle drop bytes.
    q = '{8'hE0, 8'hF0};
    repeat (2) tick(1'b0);
    q.push_back(8'h1C);
    do_reset(2);
    wait_event("after_reset", 8'h1C, 0, 0, 8'h61, 4'h0, 1);
    q = '{8'hAA, 8'hFA};
    repeat (4) tick(1'b0);
    chk("drop_no_event", 32'(bus.key_valid), 32'd0);
    chk("drop_popped", 32'(q.size()), 32'd0);

    // Random bytes and random acks against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < 4) begin
        if ($urandom_range(0, 7) == 0) q.push_back(8'($urandom));
        else q.push_back(pool[$urandom_range(0, 15)]);
      end
      tick(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1'b1);
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter PAUSE_SKIP, default 7: number of bytes discarded after an E1 prefix (Pause key sequence).
REQ-002 clk  in  1  system clock (50 MHz); the single clock domain.
REQ-003 clrn  in  1  reset, synchronous, active-high.
REQ-004 kb_data  in  8  scan-code byte at the head of the upstream PS/2 FIFO; valid whenever kb_ready=1.
REQ-005 kb_ready  in  1  upstream FIFO non-empty.
REQ-006 kb_rdn  out  1  single-cycle pop strobe to the upstream FIFO, active high.
REQ-007 key_code  out  8  final (non-prefix) scan code of the event.
REQ-008 key_ext  out  1  event was E0- or E1-prefixed.
REQ-009 key_break  out  1  1 = key release (F0-prefixed), 0 = press.
REQ-010 key_ascii  out  8  ASCII for the event, 0x00 if not translatable.
REQ-011 key_mods  out  4  {caps_lock, alt, ctrl, shift} after this event is applied.
REQ-012 key_valid  out  1  event register holds an unconsumed event.
REQ-013 key_ack  in  1  consumer accepts the event; meaningful only while key_valid=1.

Function
REQ-014 FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP; held in registers, advanced only on pop cycles.
REQ-015 kb_rdn is asserted only when kb_ready=1 and the byte may be consumed this cycle; kb_data is sampled on the same rising edge kb_rdn is high.
REQ-016 Prefix bytes (E0, F0) and discarded bytes are always consumable; a terminal byte is consumable only if the event register can load, i.e. key_valid=0 or key_ack=1.
REQ-017 Back-to-back pops are permitted; one byte per cycle maximum.
REQ-018 Transitions: IDLE+E0->GOT_E0; IDLE+F0->GOT_F0; GOT_E0+F0->GOT_E0F0; any state except SKIP +E1 -> SKIP with counter=PAUSE_SKIP; other byte in IDLE/GOT_E0/GOT_F0/GOT_E0F0 -> terminal, return to IDLE.
REQ-019 Terminal byte loads event: key_code=byte, key_ext=1 if from GOT_E0/GOT_E0F0, key_break=1 if from GOT_F0/GOT_E0F0.
REQ-020 SKIP: decrement counter per popped byte; on the byte that brings counter to 0, emit key_code=0xE1, key_ext=1, key_break=0 (subject to REQ-016), return to IDLE.
REQ-021 Bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF arriving in IDLE are popped and dropped with no event and no state change.
REQ-022 E0 or F0 repeated in a prefix state: F0 in GOT_F0/GOT_E0F0 and E0 in GOT_E0/GOT_F0/GOT_E0F0 reset the sequence to GOT_F0/GOT_E0 respectively (latest prefix wins, ext flag cleared).
REQ-023 Modifier tracking on non-ext and ext terminals: 0x12 or 0x59 -> shift; 0x14 -> ctrl; 0x11 -> alt; set on make, clear on break; shift is the OR of left and right, tracked separately.
REQ-024 caps_lock toggles on make of 0x58 only; break has no effect; typematic repeats of 0x58 each toggle.
REQ-025 key_mods in the event register reflects modifier state including the event itself.
REQ-026 key_ascii: non-ext make/break of set-2 codes for a-z, 0-9, space (0x29) -> 0x20, enter (0x5A) -> 0x0D; letters upper-case iff shift XOR caps_lock; digits unaffected by shift; everything else 0x00.
REQ-027 key_valid set on load; cleared the cycle after key_valid&key_ack unless a new event loads in that same ack cycle, in which case it stays 1 with new contents.
REQ-028 Event outputs are stable while key_valid=1 and key_ack=0.
REQ-029 Latency: terminal byte with kb_ready=1 and event register free -> key_valid=1 on the next cycle.

Reset
REQ-030 clrn=1 at a clock edge: state=IDLE, skip counter=0, all modifiers and caps_lock=0, key_valid=0, key_code=0, key_ext=0, key_break=0, key_ascii=0, kb_rdn=0.
REQ-031 Reset mid-sequence (e.g. after E0 F0) discards the partial sequence; the next byte is decoded from IDLE.
REQ-032 kb_rdn is 0 during every reset cycle.

Verification
REQ-033 Bytes 1C then F0 1C, ack each -> events {1C,ext0,brk0,ascii 0x61} then {1C,ext0,brk1,ascii 0x61}.
REQ-034 Bytes 12, 1C, F0 12, 1C -> events ascii 0x41 (mods shift=1) then after shift break ascii 0x61; 58 make between -> next 1C gives 0x41 with caps=1.
REQ-035 Bytes E0 F0 75 -> one event {75,ext1,brk1,ascii 00}; E0 and F0 produce no event.
REQ-036 E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,ext1,brk0}; all 8 bytes popped.
REQ-037 Hold key_ack=0 with bytes 1C 32 queued -> 1C event held stable, no pop of 32 until ack; ack cycle loads 32 with key_valid staying 1.
REQ-038 Assert clrn after E0 F0, then feed 1C -> event {1C,ext0,brk0}; AA and FA injected in IDLE -> popped, no event.
